// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit_if
// Description : Bundle of the request, response and byte-SRAM signals of the
//               load/store unit.
//               master modport : CPU datapath side (drives requests) plus
//                                the SRAM read-data return.
//               slave modport  : the load/store unit itself.
// Ports       : req_valid/req_ready/req_we/req_addr/req_wdata/req_memsrc
//               resp_valid/resp_rdata/resp_err
//               mem_addr/mem_re/mem_we/mem_wdata/mem_rdata
// Revision    : 1.0 - initial release
// ============================================================================
interface load_store_unit_if #(
  parameter int A_WIDTH = 20
);
  // request channel
  logic               req_valid;
  logic               req_ready;
  logic               req_we;
  logic [31:0]        req_addr;
  logic [31:0]        req_wdata;
  logic [2:0]         req_memsrc;
  // response channel
  logic               resp_valid;
  logic [31:0]        resp_rdata;
  logic               resp_err;
  // byte-wide SRAM port
  logic [A_WIDTH-1:0] mem_addr;
  logic               mem_re;
  logic               mem_we;
  logic [7:0]         mem_wdata;
  logic [7:0]         mem_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_memsrc, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_re, mem_we, mem_wdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_memsrc, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_re, mem_we, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Multi-cycle load/store initiator. Serialises one 1/2/4-byte
//               request into little-endian byte accesses on a byte-wide
//               synchronous SRAM, reassembles and sign/zero-extends loads,
//               and returns a one-cycle response pulse.
// Ports       : clk    - clock, rising edge
//               rst_n  - asynchronous active-low reset
//               bus    - load_store_unit_if.slave (request, response, SRAM)
// Options     : LSU_MISALIGN_TRAP_EN - when defined, misaligned half/word
//               requests are answered immediately with resp_err=1 and no
//               SRAM access; otherwise they are performed byte-serially.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
  parameter int A_WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  load_store_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;

  // latched request
  logic               we;
  logic [A_WIDTH-1:0] base;
  logic [31:0]        wdata;
  logic               zext;
  logic [1:0]         last;      // byte count minus one
  logic [1:0]         idx;
  logic [3:0][7:0]    lanes;
  logic [31:0]        rdata_q;
  logic               err_q;

  logic [1:0]         req_last;
  logic               trap;
  logic               handshake;
  logic               xfer;
  logic [31:0]        merged;
  logic [31:0]        load_ext;
  logic               fill;
  logic               unused_addr_hi;

  // Address bits above the SRAM width carry no meaning here.
  assign unused_addr_hi = ^bus.req_addr[31:A_WIDTH];

  always_comb begin
    case (bus.req_memsrc[1:0])
      2'b00:   req_last = 2'd0;
      2'b01:   req_last = 2'd1;
      default: req_last = 2'd3;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = ((req_last == 2'd1) & bus.req_addr[0]) |
                ((req_last == 2'd3) & (|bus.req_addr[1:0]));
`else
  assign trap = 1'b0;
`endif

  assign handshake = bus.req_valid & (state == IDLE);
  assign xfer      = (state == XFER);

  // The last byte of a load arrives in DRAIN, so it is merged straight from
  // mem_rdata rather than waiting another cycle for it to land in a lane.
  always_comb begin
    merged                        = lanes;
    merged[{last, 3'b000} +: 8]   = bus.mem_rdata;
    fill                          = 1'b0;
    load_ext                      = merged;
    case (last)
      2'd0: begin
        fill     = ~zext & merged[7];
        load_ext = {{24{fill}}, merged[7:0]};
      end
      2'd1: begin
        fill     = ~zext & merged[15];
        load_ext = {{16{fill}}, merged[15:0]};
      end
      default: load_ext = merged;
    endcase
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.req_valid) state_nxt = trap ? RESP : XFER;
      XFER:    if (idx == last)   state_nxt = we ? RESP : DRAIN;
      DRAIN:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we      <= 1'b0;
      base    <= '0;
      wdata   <= '0;
      zext    <= 1'b0;
      last    <= 2'd0;
      idx     <= 2'd0;
      lanes   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (handshake) begin
            we    <= bus.req_we;
            base  <= bus.req_addr[A_WIDTH-1:0];
            wdata <= bus.req_wdata;
            zext  <= bus.req_memsrc[2];
            last  <= req_last;
            idx   <= 2'd0;
            if (trap) begin
              rdata_q <= '0;
              err_q   <= 1'b1;
            end
          end
        end
        XFER: begin
          // read data for byte idx-1 is returned while byte idx is issued
          if (!we && (idx != 2'd0)) lanes[idx - 2'd1] <= bus.mem_rdata;
          if (idx == last) begin
            if (we) begin
              rdata_q <= '0;
              err_q   <= 1'b0;
            end
          end else begin
            idx <= idx + 2'd1;
          end
        end
        DRAIN: begin
          lanes[last] <= bus.mem_rdata;
          rdata_q     <= load_ext;
          err_q       <= 1'b0;
        end
        RESP: begin
          idx <= 2'd0;
        end
        default: idx <= 2'd0;
      endcase
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign bus.mem_re     = xfer & ~we;
  assign bus.mem_we     = xfer & we;
  assign bus.mem_addr   = xfer ? (base + A_WIDTH'(idx)) : '0;
  assign bus.mem_wdata  = (xfer & we) ? wdata[{idx, 3'b000} +: 8] : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit. Holds a byte-wide
//               SRAM model driven by the DUT and a separate reference byte
//               array from which expected load results and SRAM contents are
//               computed with plain arithmetic. Follows LSU_MISALIGN_TRAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;
  localparam int A_WIDTH = 20;
  localparam int MASK    = (1 << A_WIDTH) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if #(.A_WIDTH(A_WIDTH)) bus ();
  load_store_unit #(.A_WIDTH(A_WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [7:0] sram    [0:MASK];
  logic [7:0] ref_mem [0:MASK];
  logic        pl_en;
  logic [19:0] pl_addr;
  logic [7:0]  pl_data;

  // synchronous byte SRAM: read data valid the cycle after mem_re
  always @(posedge clk) begin
    if (pl_en)           sram[pl_addr] <= pl_data;
    else if (bus.mem_we) sram[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_re)      bus.mem_rdata <= sram[bus.mem_addr];
  end

  int vectors = 0;
  int errors  = 0;

  function automatic int nbytes(input logic [2:0] ms);
    return ms[1] ? 4 : (ms[0] ? 2 : 1);
  endfunction

  function automatic bit misaligned(input logic [31:0] addr, input logic [2:0] ms);
    int n = nbytes(ms);
    return (n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00);
  endfunction

  function automatic bit trap_build();
`ifdef LSU_MISALIGN_TRAP_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [2:0] ms);
    int n = nbytes(ms);
    logic [31:0] v = 32'd0;
    for (int i = 0; i < n; i++)
      v = v | (32'(ref_mem[(addr + i) & MASK]) << (8 * i));
    if (n < 4 && !ms[2] && v[8*n-1])
      v = v | ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  task automatic model_store(input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] ms);
    for (int i = 0; i < nbytes(ms); i++)
      ref_mem[(addr + i) & MASK] = wd[8*i +: 8];
  endtask

  // Issues one request from idle and waits (bounded) for its response.
  // lat is the response cycle relative to the handshake cycle, -1 on timeout.
  task automatic do_op(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [2:0] ms, output logic [31:0] rd, output logic err,
                       output int lat, output int re_cnt, output int we_cnt, output int both);
    rd = '0; err = 1'b0; lat = -1; re_cnt = 0; we_cnt = 0; both = 0;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    bus.req_memsrc = ms;
    @(posedge clk);
    #1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'($urandom);
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
    bus.req_memsrc = 3'($urandom);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      re_cnt += int'(bus.mem_re);
      we_cnt += int'(bus.mem_we);
      if (bus.mem_re && bus.mem_we) both++;
      if (bus.resp_valid) begin
        lat = k;
        rd  = bus.resp_rdata;
        err = bus.resp_err;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic preload();
    int bases [3] = '{32'h000F_FFF0, 32'h0000_0000, 32'h0001_0000};
    int sizes [3] = '{16, 32, 32};
    pl_en = 1'b1;
    for (int w = 0; w < 3; w++)
      for (int i = 0; i < sizes[w]; i++) begin
        pl_addr = 20'(bases[w] + i);
        pl_data = 8'($urandom);
        ref_mem[bases[w] + i] = pl_data;
        @(posedge clk);
        #1;
      end
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] zero32 = '0;
    vectors++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", bus.req_ready); end
    vectors++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", bus.resp_valid); end
    vectors++; if (bus.resp_rdata !== zero32) begin errors++; $display("FAIL reset_resp_rdata: got %h expected 0", bus.resp_rdata); end
    vectors++; if (bus.resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err: got %b expected 0", bus.resp_err); end
    vectors++; if (bus.mem_re !== 1'b0 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_strobes: got re=%b we=%b expected 0/0", bus.mem_re, bus.mem_we); end
    vectors++; if (bus.mem_addr !== 20'h0 || bus.mem_wdata !== 8'h0) begin errors++; $display("FAIL reset_mem_bus: got addr=%h wdata=%h expected 0/0", bus.mem_addr, bus.mem_wdata); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    vectors++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b expected 1", bus.req_ready); end
  endtask

  task automatic test_word_roundtrip();
    logic [31:0] rd; logic err; int lat, rc, wc, bh;
    logic [7:0] exp_b [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    do_op(1'b1, 32'h0001_0000, 32'hDEAD_BEEF, 3'b010, rd, err, lat, rc, wc, bh);
    model_store(32'h0001_0000, 32'hDEAD_BEEF, 3'b010);
    vectors++; if (lat !== 5) begin errors++; $display("FAIL store_word_latency: got %0d expected 5", lat); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (sram[32'h10000 + i] !== exp_b[i]) begin errors++; $display("FAIL store_word_byte%0d: got %h expected %h", i, sram[32'h10000 + i], exp_b[i]); end
    end
    do_op(1'b0, 32'h0001_0000, 32'h0, 3'b010, rd, err, lat, rc, wc, bh);
    vectors++; if (lat !== 6) begin errors++; $display("FAIL load_word_latency: got %0d expected 6", lat); end
    vectors++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_word_data: got %h expected deadbeef", rd); end
  endtask

  task automatic test_sign_extend();
    logic [31:0] rd; logic err; int lat, rc, wc, bh;
    do_op(1'b1, 32'h0001_0008, 32'h0000_0080, 3'b000, rd, err, lat, rc, wc, bh);
    model_store(32'h0001_0008, 32'h0000_0080, 3'b000);
    do_op(1'b0, 32'h0001_0008, 32'h0, 3'b000, rd, err, lat, rc, wc, bh);
    vectors++; if (lat !== 3) begin errors++; $display("FAIL load_byte_latency: got %0d expected 3", lat); end
    vectors++; if (rd !== 32'hFFFF_FF80) begin errors++; $display("FAIL load_byte_signed: got %h expected ffffff80", rd); end
    do_op(1'b0, 32'h0001_0008, 32'h0, 3'b100, rd, err, lat, rc, wc, bh);
    vectors++; if (rd !== 32'h0000_0080) begin errors++; $display("FAIL load_byte_zext: got %h expected 00000080", rd); end
    do_op(1'b1, 32'h0001_000A, 32'h0000_F234, 3'b001, rd, err, lat, rc, wc, bh);
    model_store(32'h0001_000A, 32'h0000_F234, 3'b001);
    do_op(1'b0, 32'h0001_000A, 32'h0, 3'b001, rd, err, lat, rc, wc, bh);
    vectors++; if (rd !== 32'hFFFF_F234) begin errors++; $display("FAIL load_half_signed: got %h expected fffff234", rd); end
    do_op(1'b0, 32'h0001_000A, 32'h0, 3'b101, rd, err, lat, rc, wc, bh);
    vectors++; if (rd !== 32'h0000_F234) begin errors++; $display("FAIL load_half_zext: got %h expected 0000f234", rd); end
  endtask

  task automatic test_wrap();
    logic [31:0] rd; logic err; int lat, rc, wc, bh;
    do_op(1'b1, 32'h000F_FFFF, 32'h0000_1234, 3'b001, rd, err, lat, rc, wc, bh);
    if (!trap_build()) begin
      model_store(32'h000F_FFFF, 32'h0000_1234, 3'b001);
      vectors++; if (sram[20'hFFFFF] !== 8'h34) begin errors++; $display("FAIL wrap_byte_hi: got %h expected 34", sram[20'hFFFFF]); end
      vectors++; if (sram[20'h00000] !== 8'h12) begin errors++; $display("FAIL wrap_byte_lo: got %h expected 12", sram[20'h00000]); end
    end else begin
      vectors++; if (err !== 1'b1 || wc !== 0) begin errors++; $display("FAIL wrap_trap: got err=%b writes=%0d expected 1/0", err, wc); end
    end
    vectors++; if (sram[20'hFFFFE] !== ref_mem[20'hFFFFE]) begin errors++; $display("FAIL wrap_neighbour_below: got %h expected %h", sram[20'hFFFFE], ref_mem[20'hFFFFE]); end
    vectors++; if (sram[20'h00001] !== ref_mem[20'h00001]) begin errors++; $display("FAIL wrap_neighbour_above: got %h expected %h", sram[20'h00001], ref_mem[20'h00001]); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ready_bits = '0;
    logic [7:0] resp_bits  = '0;
    logic [31:0] exp_rd = model_load(32'h0001_0003, 3'b000);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_addr   = 32'h0001_0003;
    bus.req_memsrc = 3'b000;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      ready_bits[c] = bus.req_ready;
      resp_bits[c]  = bus.resp_valid;
      if (bus.resp_valid) begin
        vectors++;
        if (bus.resp_rdata !== exp_rd) begin errors++; $display("FAIL b2b_data: got %h expected %h", bus.resp_rdata, exp_rd); end
      end
      if (c < 7) @(posedge clk);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    vectors++; if (ready_bits !== 8'b0001_0001) begin errors++; $display("FAIL b2b_ready: got %b expected 00010001", ready_bits); end
    vectors++; if (resp_bits !== 8'b1000_1000) begin errors++; $display("FAIL b2b_resp: got %b expected 10001000", resp_bits); end
  endtask

  task automatic test_reset_midstore();
    int fired = 0;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_addr   = 32'h0001_0010;
    bus.req_wdata  = 32'hA1B2_C3D4;
    bus.req_memsrc = 3'b010;
    @(posedge clk); #1;                 // cycle T+1
    bus.req_valid  = 1'b0;
    @(posedge clk); #1;                 // cycle T+2
    @(posedge clk); #1;                 // cycle T+3: third byte
    vectors++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 20'h10012) begin errors++; $display("FAIL midstore_third_byte: got we=%b addr=%h expected 1/10012", bus.mem_we, bus.mem_addr); end
    rst_n = 1'b0;
    #1;
    vectors++; if (bus.mem_we !== 1'b0 || bus.mem_re !== 1'b0) begin errors++; $display("FAIL midstore_strobes: got re=%b we=%b expected 0/0", bus.mem_re, bus.mem_we); end
    vectors++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin errors++; $display("FAIL midstore_handshake: got ready=%b resp=%b expected 1/0", bus.req_ready, bus.resp_valid); end
    vectors++; if (bus.mem_addr !== 20'h0) begin errors++; $display("FAIL midstore_addr: got %h expected 0", bus.mem_addr); end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    ref_mem[20'h10010] = 8'hD4;
    ref_mem[20'h10011] = 8'hC3;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.resp_valid) fired++;
    end
    @(posedge clk); #1;
    vectors++; if (fired !== 0) begin errors++; $display("FAIL midstore_no_resp: got %0d pulses expected 0", fired); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (sram[20'h10010 + i] !== ref_mem[20'h10010 + i]) begin errors++; $display("FAIL midstore_byte%0d: got %h expected %h", i, sram[20'h10010 + i], ref_mem[20'h10010 + i]); end
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] rd; logic err; int lat, rc, wc, bh;
    logic [31:0] exp_rd = model_load(32'h0001_0002, 3'b010);
    do_op(1'b0, 32'h0001_0002, 32'h0, 3'b010, rd, err, lat, rc, wc, bh);
    if (trap_build()) begin
      vectors++; if (lat !== 1 || err !== 1'b1) begin errors++; $display("FAIL misalign_trap: got lat=%0d err=%b expected 1/1", lat, err); end
      vectors++; if (rd !== 32'h0 || rc !== 0) begin errors++; $display("FAIL misalign_trap_quiet: got rdata=%h reads=%0d expected 0/0", rd, rc); end
    end else begin
      vectors++; if (lat !== 6 || err !== 1'b0) begin errors++; $display("FAIL misalign_serial: got lat=%0d err=%b expected 6/0", lat, err); end
      vectors++; if (rd !== exp_rd) begin errors++; $display("FAIL misalign_data: got %h expected %h", rd, exp_rd); end
    end
  endtask

  task automatic test_random();
    int bases [3] = '{32'h000F_FFF0, 32'h0000_0000, 32'h0001_0000};
    for (int t = 0; t < 60; t++) begin
      logic [31:0] rd, wd, addr, exp_rd;
      logic [2:0]  ms;
      logic        we, err, exp_err;
      int lat, rc, wc, bh, n, exp_lat;
      addr   = {12'($urandom), 20'(bases[$urandom_range(0, 2)] + $urandom_range(0, 15))};
      ms     = 3'($urandom);
      we     = 1'($urandom);
      wd     = $urandom;
      n      = nbytes(ms);
      exp_err = 1'b0;
      if (trap_build() && misaligned(addr, ms)) begin
        exp_rd = '0; exp_err = 1'b1; exp_lat = 1;
      end else if (we) begin
        exp_rd = '0; exp_lat = n + 1;
      end else begin
        exp_rd = model_load(addr, ms); exp_lat = n + 2;
      end
      do_op(we, addr, wd, ms, rd, err, lat, rc, wc, bh);
      vectors++; if (lat !== exp_lat) begin errors++; $display("FAIL rand%0d_latency: got %0d expected %0d", t, lat, exp_lat); end
      vectors++; if (rd !== exp_rd || err !== exp_err) begin errors++; $display("FAIL rand%0d_resp: got %h/%b expected %h/%b", t, rd, err, exp_rd, exp_err); end
      vectors++; if (bus.resp_rdata !== exp_rd) begin errors++; $display("FAIL rand%0d_hold: got %h expected %h", t, bus.resp_rdata, exp_rd); end
      vectors++;
      if (bh !== 0 || (exp_err ? (rc + wc) : (we ? wc : rc)) !== (exp_err ? 0 : n) || (we ? rc : wc) !== 0) begin
        errors++; $display("FAIL rand%0d_strobes: got re=%0d we=%0d both=%0d expected %0d %s", t, rc, wc, bh, exp_err ? 0 : n, we ? "writes" : "reads");
      end
      if (we && !exp_err) begin
        model_store(addr, wd, ms);
        for (int i = 0; i < 4; i++) begin
          int a = (addr + i) & MASK;
          vectors++;
          if (sram[a] !== ref_mem[a]) begin errors++; $display("FAIL rand%0d_mem%0d: got %h expected %h", t, i, sram[a], ref_mem[a]); end
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_memsrc = '0;
    pl_en   = 1'b0;
    pl_addr = '0;
    pl_data = '0;
    @(posedge clk); #1;
    preload();
    test_reset();
    test_word_roundtrip();
    test_sign_extend();
    test_wrap();
    test_back_to_back();
    test_reset_midstore();
    test_misaligned();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store initiator between the CPU datapath and a byte-wide synchronous data SRAM. It accepts one load or store request per handshake and serialises it into 1, 2 or 4 little-endian byte accesses. For loads it reassembles and sign- or zero-extends the result, then returns it with a single-cycle response pulse. It sits in the memory stage, in front of the byte-wide RAM macro.

## Interface
- A_WIDTH, 20, memory address width; byte addresses wrap modulo 2**A_WIDTH
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- req_valid  in  1  request present
- req_ready  out  1  unit idle and able to accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address; bits above A_WIDTH-1 ignored
- req_wdata  in  32  store data; bytes used LSB first
- req_memsrc  in  3  size and sign: [1:0] 00 byte, 01 half, 1x word; [2] 1 = zero-extend loads
- resp_valid  out  1  one-cycle completion pulse for loads and stores
- resp_rdata  out  32  extended load data; 0 for stores
- resp_err  out  1  misalignment error, valid with resp_valid
- mem_addr  out  A_WIDTH  SRAM byte address
- mem_re  out  1  SRAM read strobe
- mem_we  out  1  SRAM write strobe
- mem_wdata  out  8  SRAM write byte
- mem_rdata  in  8  SRAM read byte, valid the cycle after mem_re

## Operation
- Byte count N: 1 for 00, 2 for 01, 4 for 10 or 11. req_memsrc[2] is ignored for word loads and for all stores.
- States:
  - IDLE: req_ready=1. A handshake (req_valid & req_ready) latches we, addr, wdata, memsrc, and N; sets idx=0; moves to XFER.
- XFER, one byte per cycle:
  - mem_addr = (base + idx) mod 2**A_WIDTH.
  - Store: mem_we=1, mem_wdata = wdata byte idx.
  - Load: mem_re=1. When idx>0, mem_rdata is captured into lane idx-1.
  - When idx==N-1: a store goes to RESP, a load goes to DRAIN. Otherwise idx increments.
- DRAIN (loads only): capture mem_rdata into lane N-1; no strobes; move to RESP.
- RESP:
  - resp_valid=1 for exactly one cycle.
  - Load: resp_rdata = assembled bytes, with bits above 8*N filled by the sign bit (bit 8*N-1) or by 0 when memsrc[2]=1.
  - Store: resp_rdata=0.
  - Always returns to IDLE.
- No response backpressure; the consumer must take resp_valid in the same cycle.
- req_ready=0 in every state except IDLE. req_* inputs are ignored outside the handshake.
- Misaligned addresses are legal (byte-serial access). An address that crosses 2**A_WIDTH-1 wraps to 0.
- mem_re and mem_we are never high together; both are 0 outside XFER.
- Reset, any state including mid-transfer:
  - Immediately: state=IDLE, idx=0, lanes=0.
  - Output values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - A partially written store stays partially written in the SRAM.

## Timing
- T = cycle in which the handshake occurs.
- Store: bytes written in T+1..T+N. resp_valid in T+N+1.
- Load: reads issued in T+1..T+N. resp_valid in T+N+2. So a byte load responds in T+3 and a word load in T+6.
- Earliest next accept: cycle after RESP (store T+N+2, load T+N+3).
- resp_rdata and resp_err are registered and hold their values until the next RESP.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - A half request with addr[0]=1, or a word request with addr[1:0]!=0, is still accepted.
  - The unit then goes straight to RESP with no SRAM access: resp_valid=1 and resp_err=1 in T+1, resp_rdata=0.
- Not defined: resp_err is constant 0 and misaligned requests are performed byte-serially.

## Test plan
- Store word 0xDEADBEEF at 0x10000, then load word: bytes EF,BE,AD,DE land at 0x10000..0x10003; load returns 0xDEADBEEF with resp_valid exactly in T+6.
- Load byte with memsrc=000 from an address holding 0x80 -> 0xFFFFFF80. The same load with memsrc=100 -> 0x00000080.
- Load half with memsrc=001 from bytes 0x34,0xF2 -> 0xFFFFF234. With memsrc=101 -> 0x0000F234.
- Store half 0x1234 at 0xFFFFF (A_WIDTH=20): 0x34 is written at 0xFFFFF and 0x12 at 0x00000; nothing else changes.
- Hold req_valid high continuously with back-to-back byte loads: they are accepted at cycle 0 and cycle 4, and req_ready is low for cycles 1-3.
- Assert rst_n=0 during the third byte of a word store: strobes drop immediately, req_ready=1, resp_valid never fires, and the first two bytes remain written. With LSU_MISALIGN_TRAP_EN, a word load at 0x10002 gives resp_err=1 in T+1 with no mem_re.
